// File: rtl/arbiter_rr_4x1_pkg.sv
// Shared definitions for the 4-lane round-robin arbiter: FSM state codes,
// lane count, default widths and a one-hot to index helper.
package arbiter_pkg;

    localparam int NUM_LANES      = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_AF_WIDTH   = 3;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } arb_state_e;

    // Convert a one-hot lane vector into its lane index (0 when empty).
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/arbiter_rr_4x1_if.sv
// Lane-side and downstream-side bus of the round-robin arbiter.
// master: the arbiter; slave: the lane FIFOs plus the downstream FIFO.
interface arbiter_rr_4x1_if
    import arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AF_WIDTH   = DEF_AF_WIDTH
) ();

    logic [3:0]            fifo_empty;
    logic [DATA_WIDTH-1:0] data_0_in;
    logic [DATA_WIDTH-1:0] data_1_in;
    logic [DATA_WIDTH-1:0] data_2_in;
    logic [DATA_WIDTH-1:0] data_3_in;
    logic [3:0]            pop;
    logic [AF_WIDTH-1:0]   out_fill;
    logic                  push;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        input  fifo_empty, data_0_in, data_1_in, data_2_in, data_3_in, out_fill,
        output pop, push, data_out
    );

    modport slave (
        output fifo_empty, data_0_in, data_1_in, data_2_in, data_3_in, out_fill,
        input  pop, push, data_out
    );

endinterface

// File: rtl/arbiter_rr_4x1_rr_grant.sv
// Combinational round-robin grant finder: picks the first requesting lane
// searching circularly from ptr+1.
module rr_grant_4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic       gnt_valid
);

    logic [7:0] dbl_s;
    logic [2:0] base_s;
    logic [3:0] rot_s;
    logic [1:0] off_s;
    logic [1:0] idx_s;

    assign dbl_s  = {req, req};
    assign base_s = {1'b0, ptr} + 3'd1;
    assign rot_s  = dbl_s[base_s +: 4];

    // Priority search over the rotated request vector, then rotate back.
    always_comb begin
        off_s     = 2'd0;
        gnt_valid = 1'b0;
        casez (rot_s)
            4'b???1: begin off_s = 2'd0; gnt_valid = 1'b1; end
            4'b??10: begin off_s = 2'd1; gnt_valid = 1'b1; end
            4'b?100: begin off_s = 2'd2; gnt_valid = 1'b1; end
            4'b1000: begin off_s = 2'd3; gnt_valid = 1'b1; end
            default: begin off_s = 2'd0; gnt_valid = 1'b0; end
        endcase
        idx_s = ptr + 2'd1 + off_s;
        if (gnt_valid) begin
            gnt = 4'b0001 << idx_s;
        end else begin
            gnt = 4'b0000;
        end
    end

endmodule

// File: rtl/arbiter_rr_4x1.sv
// 4-to-1 round-robin arbiter draining four show-ahead lane FIFOs into one
// downstream FIFO, throttled by an almost-full threshold loaded in INIT.
// Optional per-lane pop counters are built when ARB_STATS_EN is defined.
module arbiter_rr_4x1
    import arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AF_WIDTH   = DEF_AF_WIDTH
) (
    input  logic                clk_f,
    input  logic                reset,
    input  logic                init,
    input  logic [AF_WIDTH-1:0] umbral_af_in,
    output logic [1:0]          state,
    output logic                idle_out,
    arbiter_rr_4x1_if.master    bus
`ifdef ARB_STATS_EN
    ,
    output logic [7:0]          cnt_0,
    output logic [7:0]          cnt_1,
    output logic [7:0]          cnt_2,
    output logic [7:0]          cnt_3
`endif
);

    arb_state_e            state_r;
    arb_state_e            state_next_s;
    logic [1:0]            ptr_r;
    logic [AF_WIDTH-1:0]   umbral_af_r;
    logic                  af_s;
    logic [3:0]            req_s;
    logic [3:0]            gnt_s;
    logic                  gnt_valid_s;
    logic [3:0]            pop_s;
    logic                  push_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic [DATA_WIDTH-1:0] data_gnt_s;
    logic                  idle_r;

    assign req_s = ~bus.fifo_empty;
    assign af_s  = (bus.out_fill >= umbral_af_r);

    rr_grant_4 u_grant (
        .req       (req_s),
        .ptr       (ptr_r),
        .gnt       (gnt_s),
        .gnt_valid (gnt_valid_s)
    );

    // FSM state register.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; init overrides the normal flow.
    always_comb begin
        state_next_s = state_r;
        if (init) begin
            state_next_s = ST_INIT;
        end else begin
            case (state_r)
                ST_RESET: state_next_s = ST_INIT;
                ST_INIT:  state_next_s = ST_IDLE;
                ST_IDLE: begin
                    if (req_s != 4'b0000) begin
                        state_next_s = ST_ACTIVE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if ((bus.fifo_empty == 4'b1111) && (pop_s == 4'b0000)) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_ACTIVE;
                    end
                end
                default: state_next_s = ST_RESET;
            endcase
        end
    end

    // FSM outputs: pop only in ACTIVE, below threshold, without init/reset.
    always_comb begin
        pop_s = 4'b0000;
        if (!reset && !init && (state_r == ST_ACTIVE) && !af_s && gnt_valid_s) begin
            pop_s = gnt_s;
        end else begin
            pop_s = 4'b0000;
        end
    end

    // Head word of the granted lane.
    always_comb begin
        data_gnt_s = '0;
        case (onehot_to_idx(gnt_s))
            2'd0:    data_gnt_s = bus.data_0_in;
            2'd1:    data_gnt_s = bus.data_1_in;
            2'd2:    data_gnt_s = bus.data_2_in;
            2'd3:    data_gnt_s = bus.data_3_in;
            default: data_gnt_s = '0;
        endcase
    end

    // Downstream write, pointer and idle flag registers.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            push_r     <= 1'b0;
            data_out_r <= '0;
            ptr_r      <= 2'd3;
            idle_r     <= 1'b0;
        end else begin
            push_r <= |pop_s;
            idle_r <= (state_next_s == ST_IDLE);
            if (|pop_s) begin
                data_out_r <= data_gnt_s;
                ptr_r      <= onehot_to_idx(pop_s);
            end
        end
    end

    // Almost-full threshold follows the input while in INIT, then holds.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            umbral_af_r <= '0;
        end else if (state_r == ST_INIT) begin
            umbral_af_r <= umbral_af_in;
        end
    end

    assign bus.pop      = pop_s;
    assign bus.push     = push_r;
    assign bus.data_out = data_out_r;
    assign state        = state_r;
    assign idle_out     = idle_r;

`ifdef ARB_STATS_EN
    logic [7:0] cnt_r [NUM_LANES];

    // Per-lane pop counters, wrapping, cleared only by reset.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                cnt_r[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (pop_s[i]) begin
                    cnt_r[i] <= cnt_r[i] + 8'd1;
                end
            end
        end
    end

    assign cnt_0 = cnt_r[0];
    assign cnt_1 = cnt_r[1];
    assign cnt_2 = cnt_r[2];
    assign cnt_3 = cnt_r[3];
`endif

endmodule

// File: tb/tb_arbiter_rr_4x1.sv
// Directed bench for arbiter_rr_4x1: the stimulus checks pop/state/idle each
// cycle and queues the expected downstream write; a monitor pops the queue
// and checks push/data_out on every cycle.
module tb_arbiter_rr_4x1;
    import arbiter_pkg::*;

    logic       clk_f = 1'b0;
    logic       reset = 1'b1;
    logic       init  = 1'b0;
    logic [2:0] umbral_af_in = 3'd5;
    logic [1:0] state;
    logic       idle_out;
    logic [7:0] d0 = 8'h10, d1 = 8'h21, d2 = 8'h32, d3 = 8'h43;
`ifdef ARB_STATS_EN
    logic [7:0] cnt_0, cnt_1, cnt_2, cnt_3;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t q[$];

    arbiter_rr_4x1_if #(.DATA_WIDTH(8), .AF_WIDTH(3)) bus ();

    assign bus.data_0_in = d0;
    assign bus.data_1_in = d1;
    assign bus.data_2_in = d2;
    assign bus.data_3_in = d3;

    arbiter_rr_4x1 #(.DATA_WIDTH(8), .AF_WIDTH(3)) dut (
        .clk_f        (clk_f),
        .reset        (reset),
        .init         (init),
        .umbral_af_in (umbral_af_in),
        .state        (state),
        .idle_out     (idle_out),
        .bus          (bus)
`ifdef ARB_STATS_EN
        ,
        .cnt_0        (cnt_0),
        .cnt_1        (cnt_1),
        .cnt_2        (cnt_2),
        .cnt_3        (cnt_3)
`endif
    );

    always #5 clk_f = ~clk_f;

    always @(posedge clk_f) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] lane_data(input logic [3:0] oh);
        logic [7:0] v;
        case (oh)
            4'b0001: v = d0;
            4'b0010: v = d1;
            4'b0100: v = d2;
            4'b1000: v = d3;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // One clock of stimulus; expected pop/state are those seen during the cycle.
    task automatic step(input logic rst, input logic ini, input logic [3:0] empty,
                        input logic [2:0] fill, input logic [3:0] exp_pop,
                        input logic [1:0] exp_state);
        exp_t e;
        @(posedge clk_f);
        #1;
        reset          = rst;
        init           = ini;
        bus.fifo_empty = empty;
        bus.out_fill   = fill;
        @(negedge clk_f);
        check("pop", {28'd0, bus.pop}, {28'd0, exp_pop});
        check("state", {30'd0, state}, {30'd0, exp_state});
        check("idle_out", {31'd0, idle_out}, {31'd0, (exp_state == ST_IDLE)});
        if (rst && (exp_state == ST_RESET)) begin
            check("data_out_reset", {24'd0, bus.data_out}, 32'd0);
        end
        if (exp_pop != 4'b0000) begin
            e.data = lane_data(exp_pop);
            e.due  = cyc + 1;
            q.push_back(e);
        end
    endtask

    // Monitor: every cycle, push must match the scoreboard's due entry.
    always @(negedge clk_f) begin
        if (q.size() > 0 && q[0].due < cyc) begin
            check("push_missing", 32'd0, 32'd1);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            check("push", {31'd0, bus.push}, 32'd1);
            check("data_out", {24'd0, bus.data_out}, {24'd0, q[0].data});
            void'(q.pop_front());
        end else begin
            check("push_idle", {31'd0, bus.push}, 32'd0);
        end
    end

    initial begin
        bus.fifo_empty = 4'b1111;
        bus.out_fill   = 3'd0;

        // Reset, then INIT with threshold 5, then IDLE.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_RESET);
        step(1'b0, 1'b1, 4'b1111, 3'd0, 4'b0000, ST_RESET);
        step(1'b0, 1'b1, 4'b1111, 3'd0, 4'b0000, ST_INIT);
        step(1'b0, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_INIT);

        // All lanes busy: lane 0 first, then circular order.
        step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b0000, ST_IDLE);
        step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b0001, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b0010, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b0100, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b1000, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b0001, ST_ACTIVE);

        // Only lane 2 holds data: granted back to back.
        d2 = 8'hA5;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b1011, 3'd0, 4'b0100, ST_ACTIVE);

        // Almost-full at fill 5 blocks pops; pointer held across the stall.
        step(1'b0, 1'b0, 4'b0000, 3'd4, 4'b1000, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b0000, 3'd5, 4'b0000, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b0000, 3'd5, 4'b0000, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b0000, 3'd4, 4'b0001, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b0000, 3'd7, 4'b0000, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b0000, 3'd4, 4'b0010, ST_ACTIVE);

        // Drain to empty, ACTIVE -> IDLE.
        step(1'b0, 1'b0, 4'b1001, 3'd0, 4'b0100, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b1101, 3'd0, 4'b0010, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_IDLE);

        // init mid-stream suppresses pop at once; pending push still lands.
        step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b0000, ST_IDLE);
        step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b0100, ST_ACTIVE);
        step(1'b0, 1'b1, 4'b0000, 3'd0, 4'b0000, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b0000, ST_INIT);
        step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b0000, ST_IDLE);
        step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b1000, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_IDLE);

`ifdef ARB_STATS_EN
        // Fresh reset, then 257 pops on lane 1: its counter wraps to 1.
        step(1'b1, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_IDLE);
        step(1'b1, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_RESET);
        step(1'b0, 1'b1, 4'b1111, 3'd0, 4'b0000, ST_RESET);
        step(1'b0, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_INIT);
        step(1'b0, 1'b0, 4'b1101, 3'd0, 4'b0000, ST_IDLE);
        for (int i = 0; i < 257; i++) step(1'b0, 1'b0, 4'b1101, 3'd0, 4'b0010, ST_ACTIVE);
        step(1'b0, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_ACTIVE);
        check("cnt_0", {24'd0, cnt_0}, 32'd0);
        check("cnt_1", {24'd0, cnt_1}, 32'd1);
        check("cnt_2", {24'd0, cnt_2}, 32'd0);
        check("cnt_3", {24'd0, cnt_3}, 32'd0);
        step(1'b0, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_IDLE);
`endif

        step(1'b0, 1'b0, 4'b1111, 3'd0, 4'b0000, ST_IDLE);
        @(negedge clk_f);
        check("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
